// File: rtl/fft_out_reorder.sv
// Output reorder buffer for the 64-point SDF FFT: bit-reversed complex stream in,
// natural-order stream out. Two banks of N words run ping-pong so that one bank
// fills while the other drains, giving gapless back-to-back frames.
module fft_out_reorder #(
    parameter int N     = 64,
    parameter int LOG2N = 6,
    parameter int DW    = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [DW-1:0]    din_r,
    input  logic signed [DW-1:0]    din_i,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [LOG2N-1:0]        out_idx,
    output logic signed [DW-1:0]    dout_r,
    output logic signed [DW-1:0]    dout_i
);

    localparam logic [0:0]       RD_IDLE   = 1'b0;
    localparam logic [0:0]       RD_RUN    = 1'b1;
    localparam logic [LOG2N-1:0] LAST_ADDR = LOG2N'(N - 1);

    // Mirror the address bits so arrival index k lands at natural index bitrev(k).
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    // Both banks in one array; the MSB of the address selects the bank.
    logic [2*DW-1:0] bank_mem [0:2*N-1];

    logic [LOG2N-1:0]     wr_cnt_q, wr_cnt_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 full;
    logic [LOG2N:0]       wr_addr;

    logic [0:0]           rd_state_q, rd_state_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0]     rd_addr_q, rd_addr_d;
    logic [2*DW-1:0]      rd_data;

    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [LOG2N-1:0]     out_idx_q, out_idx_d;
    logic signed [DW-1:0] dout_r_q, dout_r_d;
    logic signed [DW-1:0] dout_i_q, dout_i_d;

    assign wr_addr = {wr_bank_q, bitrev(wr_cnt_q)};
    assign rd_data = bank_mem[{rd_bank_q, rd_addr_q}];

    // Write-side counter: advance on each accepted sample, swap banks on the last one.
    always_comb begin
        full      = in_valid && (wr_cnt_q == LAST_ADDR);
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        if (in_valid) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (full) begin
                wr_bank_d = ~wr_bank_q;
            end
        end
    end

    // Sample storage; contents are never cleared, stale words are always overwritten first.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            bank_mem[wr_addr] <= {din_r, din_i};
        end
    end

    // Read FSM and next output word; outputs are forced to zero whenever nothing is emitted.
    always_comb begin
        rd_state_d  = rd_state_q;
        rd_bank_d   = rd_bank_q;
        rd_addr_d   = rd_addr_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_idx_d   = '0;
        dout_r_d    = '0;
        dout_i_d    = '0;
        case (rd_state_q)
            RD_IDLE: begin
                if (full) begin
                    rd_state_d = RD_RUN;
                    rd_bank_d  = wr_bank_q;
                    rd_addr_d  = '0;
                end
            end
            RD_RUN: begin
                out_valid_d = 1'b1;
                out_idx_d   = rd_addr_q;
                out_last_d  = (rd_addr_q == LAST_ADDR);
                dout_r_d    = rd_data[2*DW-1:DW];
                dout_i_d    = rd_data[DW-1:0];
                rd_addr_d   = rd_addr_q + 1'b1;
                if (rd_addr_q == LAST_ADDR) begin
                    if (full) begin
                        // Next frame just completed: continue straight into it.
                        rd_bank_d = ~rd_bank_q;
                    end else begin
                        rd_state_d = RD_IDLE;
                    end
                end
            end
            default: begin
                rd_state_d = RD_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_state_q  <= RD_IDLE;
            rd_bank_q   <= 1'b0;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            dout_r_q    <= '0;
            dout_i_q    <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_state_q  <= rd_state_d;
            rd_bank_q   <= rd_bank_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            dout_r_q    <= dout_r_d;
            dout_i_q    <= dout_i_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;
    assign dout_r    = dout_r_q;
    assign dout_i    = dout_i_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder: the driver pushes the expected natural-order
// words (with the cycle they must appear) when a frame completes; the monitor pops them.
module tb_fft_out_reorder;

    localparam int N     = 64;
    localparam int LOG2N = 6;
    localparam int DW    = 24;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] din_r = '0;
    logic signed [DW-1:0] din_i = '0;
    logic                 out_valid;
    logic                 out_last;
    logic [LOG2N-1:0]     out_idx;
    logic signed [DW-1:0] dout_r;
    logic signed [DW-1:0] dout_i;

    fft_out_reorder #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .din_r     (din_r),
        .din_i     (din_i),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .dout_r    (dout_r),
        .dout_i    (dout_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                   cyc;
        int                   idx;
        logic                 last;
        logic signed [DW-1:0] r;
        logic signed [DW-1:0] i;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic signed [DW-1:0] fr_r [N];
    logic signed [DW-1:0] fr_i [N];

    // Reference bit reversal by repeated halving/doubling.
    function automatic int rev6(input int v);
        int r = 0;
        int x = v;
        for (int b = 0; b < LOG2N; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic signed [DW-1:0] r, input logic signed [DW-1:0] i);
        @(posedge clk);
        #1;
        in_valid = v;
        din_r    = r;
        din_i    = i;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) drive(1'b0, '0, '0);
    endtask

    // One reset cycle; expectations that can no longer appear are dropped.
    task automatic reset_cycle();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        while (q.size() > 0 && q[q.size()-1].cyc > cyc) void'(q.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Send fr_* in arrival order; optionally insert an idle cycle after each sample.
    task automatic send_frame(input bit gap);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            drive(1'b1, fr_r[k], fr_i[k]);
            if (k == N - 1) begin
                for (int n = 0; n < N; n++) begin
                    e.cyc  = cyc + 2 + n;
                    e.idx  = n;
                    e.last = (n == N - 1);
                    e.r    = fr_r[rev6(n)];
                    e.i    = fr_i[rev6(n)];
                    q.push_back(e);
                end
            end else if (gap) begin
                drive(1'b0, '0, '0);
            end
        end
        #1;
        if (!gap) begin
            // fall through; caller decides whether the next frame is back-to-back
        end
    endtask

    task automatic fill_ramp(input int base);
        for (int k = 0; k < N; k++) begin
            fr_r[k] = DW'(base + k);
            fr_i[k] = DW'(-(base + k));
        end
    endtask

    // Monitor: every output cycle pops one expectation; idle cycles must show zeros.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (out_valid) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious cyc=%0d got idx=%0d r=%0d i=%0d, want no output", cyc, out_idx, dout_r, dout_i);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.cyc != cyc || e.idx != int'(out_idx) || e.last != out_last || e.r != dout_r || e.i != dout_i) begin
                        n_err++;
                        $display("FAIL out cyc=%0d got idx=%0d last=%0d r=%0d i=%0d, want cyc=%0d idx=%0d last=%0d r=%0d i=%0d",
                                 cyc, out_idx, out_last, dout_r, dout_i, e.cyc, e.idx, e.last, e.r, e.i);
                    end
                end
            end else begin
                n_vec++;
                if (out_last !== 1'b0 || out_idx !== '0 || dout_r !== '0 || dout_i !== '0) begin
                    n_err++;
                    $display("FAIL idle cyc=%0d got last=%0d idx=%0d r=%0d i=%0d, want all 0", cyc, out_last, out_idx, dout_r, dout_i);
                end
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    n_err++;
                    $display("FAIL missing cyc=%0d got out_valid=0, want idx=%0d r=%0d", cyc, q[0].idx, q[0].r);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got no finish, want finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle(3);
        #1;
        rst_n = 1'b1;
        idle(2);

        // 1: single contiguous frame, din_r=k, din_i=-k
        fill_ramp(0);
        send_frame(1'b0);
        idle(70);

        // 2: two frames back-to-back
        fill_ramp(0);
        send_frame(1'b0);
        fill_ramp(1000);
        send_frame(1'b0);
        idle(70);

        // 3: gapped input
        fill_ramp(0);
        send_frame(1'b1);
        idle(70);

        // 4: reset after 30 samples, then a full frame
        fill_ramp(500);
        for (int k = 0; k < 30; k++) drive(1'b1, fr_r[k], fr_i[k]);
        reset_cycle();
        fill_ramp(2000);
        send_frame(1'b0);
        idle(70);

        // 5: reset while out_idx=20 is on the output
        fill_ramp(3000);
        send_frame(1'b0);
        idle(21);
        reset_cycle();
        idle(80);
        fill_ramp(4000);
        send_frame(1'b0);
        idle(70);

        // 6: full-scale extremes
        for (int k = 0; k < N; k++) begin
            fr_r[k] = -24'sd8388608;
            fr_i[k] = 24'sd8388607;
        end
        send_frame(1'b0);
        idle(80);

        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending outputs, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
